// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants and operand type for the sign-magnitude ALU
package fp_pkg;

  localparam int DATA_WIDTH_DEF = 24;

  // Meaning of the symbol input: select A+B or A-B.
  localparam logic SYMBOL_ADD = 1'b0;
  localparam logic SYMBOL_SUB = 1'b1;

  typedef struct packed {
    logic                      sign;
    logic [DATA_WIDTH_DEF-1:0] magnitude;
  } operand_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter
// Ports:
//   data_i  [WIDTH]             value to scan, MSB first
//   count_o [clog2(WIDTH+1)]    number of zeros above the highest set bit, WIDTH when data_i==0
module fp_lzc #(
  parameter int WIDTH = 25
) (
  input  logic [WIDTH-1:0]             data_i,
  output logic [$clog2(WIDTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    count_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o = CW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/sm_alu_pipe.sv
// rtl/sm_alu_pipe.sv - two-stage sign-magnitude add/subtract pipeline with valid/ready handshakes
// Optional feature macro: SM_ALU_PIPE_LZC_EN adds the lz_count output.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake for one operand set
//   a, b [W]              unsigned magnitudes
//   sign_a, sign_b        operand signs, 1 = negative
//   symbol                0 = A+B, 1 = A-B
//   out_valid / out_ready output handshake
//   out [W+1]             result magnitude, MSB = carry of an effective add
//   sign_out              result sign, never set for a zero result
//   lz_count              (macro only) leading zeros of out over W+1 bits
module sm_alu_pipe
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sign_a,
  input  logic                  sign_b,
  input  logic                  symbol,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   out,
  output logic                  sign_out
`ifdef SM_ALU_PIPE_LZC_EN
  ,
  output logic [$clog2(DATA_WIDTH+2)-1:0] lz_count
`endif
);

  localparam int W = DATA_WIDTH;

  // Stage 1: captured operands and effective operation.
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  logic         s1_sign_a_q, s1_sign_a_d;
  logic         s1_eff_sub_q, s1_eff_sub_d;

  // Stage 2: registered result.
  logic         s2_valid_q, s2_valid_d;
  logic [W:0]   s2_out_q, s2_out_d;
  logic         s2_sign_q, s2_sign_d;

  logic         s2_load;
  logic         s1_adv;
  logic         in_fire;

  logic [W:0]   res_mag;
  logic         res_sign;

  // S2 is free when empty or draining; S1 may move whenever S2 takes its
  // content or it holds nothing, which lets a full pipe shift without a bubble.
  assign s2_load  = ~s2_valid_q | out_ready;
  assign s1_adv   = s2_load | ~s1_valid_q;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid & in_ready;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_sign_a_d  = s1_sign_a_q;
    s1_eff_sub_d = s1_eff_sub_q;
    if (s1_adv) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_a_d       = a;
        s1_b_d       = b;
        s1_sign_a_d  = sign_a;
        s1_eff_sub_d = sign_a ^ (symbol == SYMBOL_SUB) ^ sign_b;
      end
    end
  end

  // Magnitude arithmetic: add with carry, or subtract the smaller from the
  // larger so the result is always a non-negative magnitude.
  always_comb begin
    res_mag  = '0;
    res_sign = s1_sign_a_q;
    if (!s1_eff_sub_q) begin
      res_mag  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      res_sign = s1_sign_a_q;
    end else if (s1_a_q >= s1_b_q) begin
      res_mag  = {1'b0, s1_a_q - s1_b_q};
      res_sign = s1_sign_a_q;
    end else begin
      res_mag  = {1'b0, s1_b_q - s1_a_q};
      res_sign = ~s1_sign_a_q;
    end
    if (res_mag == '0) begin
      res_sign = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_out_d   = s2_out_q;
    s2_sign_d  = s2_sign_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_out_d  = res_mag;
        s2_sign_d = res_sign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_sign_a_q  <= 1'b0;
      s1_eff_sub_q <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_out_q     <= '0;
      s2_sign_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_sign_a_q  <= s1_sign_a_d;
      s1_eff_sub_q <= s1_eff_sub_d;
      s2_valid_q   <= s2_valid_d;
      s2_out_q     <= s2_out_d;
      s2_sign_q    <= s2_sign_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = s2_out_q;
  assign sign_out  = s2_sign_q;

`ifdef SM_ALU_PIPE_LZC_EN
  localparam int LZW = $clog2(W + 2);

  logic [LZW-1:0] lz_res;
  logic [LZW-1:0] lz_q, lz_d;

  fp_lzc #(
    .WIDTH (W + 1)
  ) u_lzc (
    .data_i  (res_mag),
    .count_o (lz_res)
  );

  // Loaded together with the S2 result so the count always describes out.
  always_comb begin
    lz_d = lz_q;
    if (s2_load && s1_valid_q) begin
      lz_d = lz_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lz_q <= LZW'(W + 1);
    end else begin
      lz_q <= lz_d;
    end
  end

  assign lz_count = lz_q;
`endif

endmodule

// File: tb/tb_sm_alu_pipe.sv
// tb/tb_sm_alu_pipe.sv - self-checking bench for sm_alu_pipe (W=24)
module tb_sm_alu_pipe;
  import fp_pkg::*;

  localparam int W   = 24;
  localparam int LZW = $clog2(W + 2);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sign_a;
  logic         sign_b;
  logic         symbol;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out;
  logic         sign_out;
`ifdef SM_ALU_PIPE_LZC_EN
  logic [LZW-1:0] lz_count;
`endif

  sm_alu_pipe #(
    .DATA_WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sign_a    (sign_a),
    .sign_b    (sign_b),
    .symbol    (symbol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .sign_out  (sign_out)
`ifdef SM_ALU_PIPE_LZC_EN
    ,
    .lz_count  (lz_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] mag;
    logic       sign;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic last_in_ready;
  logic last_in_fire;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: treat each operand as a signed integer, do the signed sum,
  // then split into magnitude and sign (zero is always positive).
  function automatic exp_t ref_model(operand_t x, operand_t y, logic sym);
    longint va, vb, r;
    exp_t   e;
    va = x.sign ? -longint'(x.magnitude) : longint'(x.magnitude);
    vb = (y.sign ^ (sym == SYMBOL_SUB)) ? -longint'(y.magnitude) : longint'(y.magnitude);
    r  = va + vb;
    e.sign = (r < 0);
    if (r < 0) r = -r;
    e.mag = r[W:0];
    return e;
  endfunction

  function automatic int ref_lz(logic [W:0] v);
    for (int i = W; i >= 0; i--) begin
      if (v[i]) return W - i;
    end
    return W + 1;
  endfunction

  task automatic drive(operand_t x, operand_t y, logic sym);
    a      = x.magnitude;
    sign_a = x.sign;
    b      = y.magnitude;
    sign_b = y.sign;
    symbol = sym;
  endtask

  // One clock of scoreboard traffic; entered and left at a falling edge.
  task automatic tick();
    exp_t     e;
    operand_t x, y;
    #1;
    last_in_ready = in_ready;
    last_in_fire  = in_valid && in_ready;
    if (exp_q.size() == 0) begin
      check("spurious_out_valid", 64'(out_valid), 64'd0);
    end else if (out_valid) begin
      e = exp_q[0];
      check("out", 64'(out), 64'(e.mag));
      check("sign_out", 64'(sign_out), 64'(e.sign));
`ifdef SM_ALU_PIPE_LZC_EN
      check("lz_count", 64'(lz_count), 64'(ref_lz(e.mag)));
`endif
      if (out_ready) void'(exp_q.pop_front());
    end
    if (last_in_fire) begin
      x.sign = sign_a; x.magnitude = a;
      y.sign = sign_b; y.magnitude = b;
      exp_q.push_back(ref_model(x, y, symbol));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single operation through an empty pipe with exact two-cycle latency.
  task automatic send_one(string tag, operand_t x, operand_t y, logic sym,
                          logic [W:0] eo, logic es, int elz);
    drive(x, y, sym);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_out"}, 64'(out), 64'(eo));
    check({tag, "_sign"}, 64'(sign_out), 64'(es));
`ifdef SM_ALU_PIPE_LZC_EN
    check({tag, "_lz"}, 64'(lz_count), 64'(elz));
`else
    if (elz < 0) check({tag, "_lz"}, 64'(elz), 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic operand_t rand_op(int mode, operand_t other);
    operand_t o;
    o.sign = 1'($urandom_range(0, 1));
    case (mode)
      0:       o.magnitude = W'($urandom);
      1:       o.magnitude = other.magnitude;
      2:       o.magnitude = '1;
      default: o.magnitude = W'($urandom_range(0, 7));
    endcase
    return o;
  endfunction

  operand_t ops_a[4];
  operand_t ops_b[4];
  logic     ops_s[4];

  initial begin
    operand_t x, y;
    int       k;
    int       budget;
    int       mode;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sign_a = 1'b0; sign_b = 1'b0; symbol = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_sign_out", 64'(sign_out), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);

    x = '{1'b0, 24'h000003}; y = '{1'b0, 24'h000005};
    send_one("add_3_5", x, y, SYMBOL_ADD, 25'h0000008, 1'b0, 21);
    x = '{1'b0, 24'hFFFFFF}; y = '{1'b0, 24'h000001};
    send_one("add_carry", x, y, SYMBOL_ADD, 25'h1000000, 1'b0, 0);
    x = '{1'b0, 24'd3}; y = '{1'b0, 24'd5};
    send_one("sub_neg", x, y, SYMBOL_SUB, 25'd2, 1'b1, 23);
    x = '{1'b1, 24'd3}; y = '{1'b1, 24'd5};
    send_one("sub_negneg", x, y, SYMBOL_SUB, 25'd2, 1'b0, 23);
    x = '{1'b1, 24'd5}; y = '{1'b0, 24'd5};
    send_one("zero_nosign", x, y, SYMBOL_ADD, 25'd0, 1'b0, 25);

    // Back-to-back inputs into a stalled output.
    for (int i = 0; i < 4; i++) begin
      ops_a[i] = rand_op(0, ops_a[0]);
      ops_b[i] = rand_op(0, ops_a[i]);
      ops_s[i] = 1'($urandom_range(0, 1));
    end
    k = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(ops_a[k], ops_b[k], ops_s[k]);
      in_valid = 1'b1;
      tick();
      check("stall_in_ready", 64'(last_in_ready), 64'(c < 2));
      if (last_in_fire) k++;
    end
    check("stall_accepted", 64'(k), 64'd2);
    out_ready = 1'b1;
    budget = 0;
    while ((k < 4 || exp_q.size() != 0) && budget < 50) begin
      if (k < 4) begin
        drive(ops_a[k], ops_b[k], ops_s[k]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (last_in_fire) k++;
      budget++;
    end
    check("stall_drain_done", 64'(exp_q.size() == 0 && k == 4), 64'd1);

    // Reset with two results in flight.
    out_ready = 1'b0;
    k = 0;
    budget = 0;
    while (k < 2 && budget < 10) begin
      drive(rand_op(3, x), rand_op(3, x), 1'($urandom_range(0, 1)));
      in_valid = 1'b1;
      tick();
      if (last_in_fire) k++;
      budget++;
    end
    check("pre_rst_accepted", 64'(k), 64'd2);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out", 64'(out), 64'd0);
    check("midrst_sign_out", 64'(sign_out), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < 6; c++) tick();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      mode = int'($urandom_range(0, 3));
      x = rand_op(mode == 1 ? 0 : mode, x);
      y = rand_op(mode, x);
      drive(x, y, 1'($urandom_range(0, 1)));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      tick();
      budget++;
    end
    check("random_drain_empty", 64'(exp_q.size()), 64'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
